// File: rtl/snoopy_bus_pkg.sv
// Shared types and helpers for the snoopy bus arbiter.
package snoopy_bus_pkg;

  // Arbiter transaction states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_stat_t;

  localparam int unsigned DEFAULT_NUM_PORTS = 2;

  // Width of a port index; never below one bit so single-port builds still elaborate.
  function automatic int unsigned port_idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? unsigned'($clog2(num_ports)) : 32'd1;
  endfunction

  localparam int unsigned PORT_IDX_W = port_idx_width(DEFAULT_NUM_PORTS);

endpackage

// File: rtl/snoopy_rr_pick.sv
// Requester picker: eligible mask (plus search start pointer) to one-hot grant and index.
// Macro SNOOPY_ARB_RR_EN: defined = round-robin from ptr_i, undefined = lowest index wins.
module snoopy_rr_pick import snoopy_bus_pkg::*; #(
  parameter  int unsigned NUM_PORTS = DEFAULT_NUM_PORTS,
  localparam int unsigned IDX_W     = port_idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible_i,
`ifdef SNOOPY_ARB_RR_EN
  input  logic [IDX_W-1:0]     ptr_i,
`endif
  output logic [NUM_PORTS-1:0] grant_oh_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_valid_o
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

`ifdef SNOOPY_ARB_RR_EN
  assign start = ptr_i;
`else
  assign start = '0;
`endif

  // Walk the ports from the start position and take the first eligible one.
  always_comb begin
    grant_oh_o    = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_W'((32'(start) + k) % NUM_PORTS);
      if (!grant_valid_o && eligible_i[cand]) begin
        grant_valid_o    = 1'b1;
        grant_idx_o      = cand;
        grant_oh_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// Arbitrates the cache ports onto one memory port and broadcasts invalidates after
// cacheable writes. Macro SNOOPY_ARB_RR_EN selects round-robin over fixed priority.
module snoopy_bus_arbiter import snoopy_bus_pkg::*; #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned MASKW      = WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            rw_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rw_addr,
  input  logic [NUM_PORTS-1:0]            rw_we,
  input  logic [NUM_PORTS*MASKW-1:0]      w_mask,
  input  logic [NUM_PORTS*WIDTH-1:0]      w_data,
  input  logic [NUM_PORTS-1:0]            w_ce,
  output logic [NUM_PORTS-1:0]            rw_ready,
  output logic [WIDTH-1:0]                r_data,
  output logic [NUM_PORTS-1:0]            inv_valid,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] inv_addr,
  input  logic [NUM_PORTS-1:0]            inv_ready,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_we,
  output logic [MASKW-1:0]                mem_wmask,
  output logic [WIDTH-1:0]                mem_wdata,
  input  logic                            mem_resp_valid,
  input  logic [WIDTH-1:0]                mem_rdata
);

  localparam int unsigned IDX_W = port_idx_width(NUM_PORTS);

  arb_stat_t                     state_q, state_d;
  logic [IDX_W-1:0]              grant_idx_q, grant_idx_d;
  logic [NUM_PORTS-1:0]          grant_oh_q, grant_oh_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic                          we_q, we_d;
  logic                          ce_q, ce_d;
  logic [MASKW-1:0]              mask_q, mask_d;
  logic [WIDTH-1:0]              data_q, data_d;
  logic [WIDTH-1:0]              rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]          inv_valid_q, inv_valid_d;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] inv_addr_q, inv_addr_d;

  logic [NUM_PORTS-1:0]          eligible;
  logic [NUM_PORTS-1:0]          pick_oh;
  logic [IDX_W-1:0]              pick_idx;
  logic                          pick_valid;
  logic                          inv_load;

`ifdef SNOOPY_ARB_RR_EN
  logic [IDX_W-1:0]              ptr_q, ptr_d;
`endif

  // Cacheable writes wait until every invalidate slot has drained; everything else goes.
  always_comb begin
    eligible = rw_valid & ~(rw_we & w_ce & {NUM_PORTS{|inv_valid_q}});
  end

  snoopy_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .eligible_i    (eligible),
`ifdef SNOOPY_ARB_RR_EN
    .ptr_i         (ptr_q),
`endif
    .grant_oh_o    (pick_oh),
    .grant_idx_o   (pick_idx),
    .grant_valid_o (pick_valid)
  );

  // Transaction FSM: capture the picked request, issue it, wait for memory, complete.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    addr_d      = addr_q;
    we_d        = we_q;
    ce_d        = ce_q;
    mask_d      = mask_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_idx_d = pick_idx;
          grant_oh_d  = pick_oh;
          for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (pick_oh[p]) begin
              addr_d = rw_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
              we_d   = rw_we[p];
              ce_d   = w_ce[p];
              mask_d = w_mask[p*MASKW +: MASKW];
              data_d = w_data[p*WIDTH +: WIDTH];
            end
          end
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

`ifdef SNOOPY_ARB_RR_EN
  // Next search starts one past the port just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ARB_IDLE && pick_valid) begin
      ptr_d = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  // Invalidate slots: loaded in the completion cycle of a cacheable write, so the
  // broadcast is visible alongside rw_ready; each drains on its own acknowledge.
  always_comb begin
    inv_load  = (state_q == ARB_RESP) && we_q && ce_q;
    inv_valid = '0;
    inv_addr  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      inv_valid[p] = inv_valid_q[p] | inv_load;
      inv_addr[p*ADDR_WIDTH +: ADDR_WIDTH] =
          inv_load ? addr_q : inv_addr_q[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
    inv_valid_d = inv_valid & ~inv_ready;
    inv_addr_d  = inv_addr;
  end

  // Outputs come straight from registered state.
  always_comb begin
    rw_ready      = (state_q == ARB_RESP) ? grant_oh_q : '0;
    r_data        = rdata_q;
    mem_req_valid = (state_q == ARB_REQ);
    mem_addr      = addr_q;
    mem_we        = we_q;
    mem_wmask     = mask_q;
    mem_wdata     = data_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      ce_q        <= 1'b0;
      mask_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      inv_valid_q <= '0;
      inv_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      ce_q        <= ce_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      inv_valid_q <= inv_valid_d;
      inv_addr_q  <= inv_addr_d;
    end
  end

`ifdef SNOOPY_ARB_RR_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

`ifndef SYNTHESIS
  // A requester must hold rw_valid from grant through its rw_ready cycle.
  a_hold_valid: assert property (@(posedge clk) disable iff (rst)
                                 (state_q != ARB_IDLE) |-> rw_valid[grant_idx_q]);
`endif

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// Directed self-checking bench for snoopy_bus_arbiter (2 ports, 32-bit addr, 128-bit data).
module tb_snoopy_bus_arbiter;

  logic          clk;
  logic          rst;
  logic [1:0]    rw_valid;
  logic [63:0]   rw_addr;
  logic [1:0]    rw_we;
  logic [31:0]   w_mask;
  logic [255:0]  w_data;
  logic [1:0]    w_ce;
  logic [1:0]    rw_ready;
  logic [127:0]  r_data;
  logic [1:0]    inv_valid;
  logic [63:0]   inv_addr;
  logic [1:0]    inv_ready;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wmask;
  logic [127:0]  mem_wdata;
  logic          mem_resp_valid;
  logic [127:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  // Memory model configuration and capture.
  logic [127:0]  mem_data;
  int            stall_cfg;
  int            resp_wait;
  logic          pend;
  int            resp_cnt;
  int            req_wait_cnt;
  int            acc_cnt;
  logic [31:0]   cap_addr;
  logic          cap_we;
  logic [15:0]   cap_mask;

  localparam logic [127:0] DEADBEEF = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;

  snoopy_bus_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rw_valid       (rw_valid),
    .rw_addr        (rw_addr),
    .rw_we          (rw_we),
    .w_mask         (w_mask),
    .w_data         (w_data),
    .w_ce           (w_ce),
    .rw_ready       (rw_ready),
    .r_data         (r_data),
    .inv_valid      (inv_valid),
    .inv_addr       (inv_addr),
    .inv_ready      (inv_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wmask      (mem_wmask),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory state: accept, count stall cycles, count down to the response.
  always @(posedge clk) begin
    if (rst) begin
      pend         <= 1'b0;
      resp_cnt     <= 0;
      req_wait_cnt <= 0;
    end else if (mem_req_valid && mem_req_ready) begin
      pend         <= 1'b1;
      resp_cnt     <= resp_wait;
      req_wait_cnt <= 0;
      cap_addr     <= mem_addr;
      cap_we       <= mem_we;
      cap_mask     <= mem_wmask;
      acc_cnt      <= acc_cnt + 1;
    end else begin
      if (mem_req_valid) req_wait_cnt <= req_wait_cnt + 1;
      if (pend && mem_resp_valid) pend <= 1'b0;
      else if (pend && resp_cnt > 0) resp_cnt <= resp_cnt - 1;
    end
  end

  // Memory-side inputs change on the falling edge.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = mem_req_valid && !pend && (req_wait_cnt >= stall_cfg);
      mem_resp_valid = pend && (resp_cnt == 0);
      mem_rdata      = (pend && resp_cnt == 0) ? mem_data : '0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input int p, input logic [31:0] a, input logic we, input logic ce,
                           input logic [15:0] m, input logic [127:0] d);
    rw_valid[p]          = 1'b1;
    rw_we[p]             = we;
    w_ce[p]              = ce;
    rw_addr[p*32 +: 32]  = a;
    w_mask[p*16 +: 16]   = m;
    w_data[p*128 +: 128] = d;
  endtask

  task automatic drop_req(input int p);
    rw_valid[p] = 1'b0;
    rw_we[p]    = 1'b0;
    w_ce[p]     = 1'b0;
  endtask

  // Advance until rw_ready[p] is seen or the budget runs out; returns cycles taken.
  task automatic wait_ready(input int p, input int budget, output int cycles);
    cycles = 0;
    while (rw_ready[p] !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (rw_ready !== 2'b00) begin errors++;
      $display("FAIL reset_rw_ready: got %b expected 00", rw_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (inv_valid !== 2'b00) begin errors++;
      $display("FAIL reset_inv_valid: got %b expected 00", inv_valid); end
    checks++; if (r_data !== 128'h0 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL reset_data: got r_data=%0h mem_addr=%0h mem_we=%b expected all 0",
               r_data, mem_addr, mem_we); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    int n0, n1, first;
    logic [127:0] rd;
    n0 = 0; n1 = 0; first = -1; rd = '0;
    mem_data = DEADBEEF;
    drive_req(0, 32'h0000_1230, 1'b0, 1'b0, 16'h0, 128'h0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (rw_ready[0] === 1'b1) begin
        n0++;
        if (first < 0) begin first = c; rd = r_data; end
      end
      if (rw_ready[1] === 1'b1) n1++;
      if (c == 4) drop_req(0);
    end
    checks++; if (first != 3) begin errors++;
      $display("FAIL read_latency: got %0d expected 3", first); end
    checks++; if (rd !== DEADBEEF) begin errors++;
      $display("FAIL read_data: got %0h expected %0h", rd, DEADBEEF); end
    checks++; if (n0 != 1) begin errors++;
      $display("FAIL read_pulse_count: got %0d expected 1", n0); end
    checks++; if (n1 != 0) begin errors++;
      $display("FAIL read_other_port: got %0d expected 0", n1); end
    checks++; if (cap_addr !== 32'h0000_1230 || cap_we !== 1'b0) begin errors++;
      $display("FAIL read_mem_req: got addr=%0h we=%b expected 1230/0", cap_addr, cap_we); end
  endtask

  task automatic test_cacheable_write();
    int cyc;
    drive_req(1, 32'h0000_2000, 1'b1, 1'b1, 16'h000F, 128'h55);
    wait_ready(1, 10, cyc);
    checks++; if (cyc != 3) begin errors++;
      $display("FAIL wr_latency: got %0d expected 3", cyc); end
    checks++; if (cap_we !== 1'b1 || cap_mask !== 16'h000F || cap_addr !== 32'h2000) begin
      errors++; $display("FAIL wr_mem_req: got we=%b mask=%0h addr=%0h expected 1/000f/2000",
                         cap_we, cap_mask, cap_addr); end
    checks++; if (rw_ready !== 2'b10) begin errors++;
      $display("FAIL wr_ready: got %b expected 10", rw_ready); end
    checks++; if (inv_valid !== 2'b11) begin errors++;
      $display("FAIL wr_inv_same_cycle: got %b expected 11", inv_valid); end
    checks++; if (inv_addr !== 64'h0000_2000_0000_2000) begin errors++;
      $display("FAIL wr_inv_addr: got %0h expected 0000200000002000", inv_addr); end
    tick();
    drop_req(1);
    inv_ready[0] = 1'b1;
    checks++; if (inv_valid !== 2'b11) begin errors++;
      $display("FAIL inv_held: got %b expected 11", inv_valid); end
    tick();
    inv_ready[0] = 1'b0;
    checks++; if (inv_valid !== 2'b10) begin errors++;
      $display("FAIL inv0_clear: got %b expected 10", inv_valid); end
    tick();
    tick();
    tick();
    checks++; if (inv_valid !== 2'b10 || inv_addr[63:32] !== 32'h2000) begin errors++;
      $display("FAIL inv1_pending: got %b/%0h expected 10/2000", inv_valid, inv_addr[63:32]); end
    inv_ready[1] = 1'b1;
    tick();
    inv_ready[1] = 1'b0;
    checks++; if (inv_valid !== 2'b00) begin errors++;
      $display("FAIL inv1_clear: got %b expected 00", inv_valid); end
  endtask

  task automatic test_write_blocked();
    int cyc, n1, acc0;
    drive_req(0, 32'h0000_3000, 1'b1, 1'b1, 16'hFFFF, 128'h1);
    wait_ready(0, 10, cyc);
    tick();
    drop_req(0);
    inv_ready = 2'b10;
    tick();
    inv_ready = 2'b00;
    checks++; if (inv_valid !== 2'b01) begin errors++;
      $display("FAIL blk_setup: got %b expected 01", inv_valid); end
    mem_data = 128'hCAFE_F00D;
    acc0 = acc_cnt;
    drive_req(1, 32'h0000_4000, 1'b1, 1'b1, 16'h00FF, 128'h2);
    drive_req(0, 32'h0000_5000, 1'b0, 1'b0, 16'h0, 128'h0);
    wait_ready(0, 10, cyc);
    checks++; if (cyc != 3 || rw_ready !== 2'b01) begin errors++;
      $display("FAIL blk_read_served: got cyc=%0d ready=%b expected 3/01", cyc, rw_ready); end
    checks++; if (r_data !== 128'hCAFE_F00D || cap_addr !== 32'h5000) begin errors++;
      $display("FAIL blk_read_data: got %0h@%0h expected cafef00d@5000", r_data, cap_addr); end
    tick();
    drop_req(0);
    n1 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rw_ready[1] === 1'b1) n1++;
    end
    checks++; if (n1 != 0 || (acc_cnt - acc0) != 1) begin errors++;
      $display("FAIL blk_write_held: got pulses=%0d accepts=%0d expected 0/1", n1, acc_cnt - acc0);
    end
    checks++; if (inv_valid !== 2'b01) begin errors++;
      $display("FAIL blk_slot_kept: got %b expected 01", inv_valid); end
    inv_ready[0] = 1'b1;
    tick();
    inv_ready[0] = 1'b0;
    wait_ready(1, 10, cyc);
    checks++; if (cyc != 3 || cap_addr !== 32'h4000) begin errors++;
      $display("FAIL blk_write_after: got cyc=%0d addr=%0h expected 3/4000", cyc, cap_addr); end
    checks++; if (inv_valid !== 2'b11 || inv_addr !== 64'h0000_4000_0000_4000) begin errors++;
      $display("FAIL blk_rebroadcast: got %b/%0h expected 11/0000400000004000",
               inv_valid, inv_addr); end
    tick();
    drop_req(1);
    inv_ready = 2'b11;
    tick();
    inv_ready = 2'b00;
    checks++; if (inv_valid !== 2'b00) begin errors++;
      $display("FAIL blk_drain: got %b expected 00", inv_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    logic [1:0] exp_g [4];
    int g;
`ifdef SNOOPY_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    seq = '{2'b00, 2'b00, 2'b00, 2'b00};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_req(0, 32'h0000_A000, 1'b0, 1'b0, 16'h0, 128'h0);
    drive_req(1, 32'h0000_B000, 1'b0, 1'b0, 16'h0, 128'h0);
    g = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      tick();
      if (rw_ready !== 2'b00) begin
        seq[g] = rw_ready;
        g++;
      end
    end
    checks++; if (g != 4) begin errors++;
      $display("FAIL b2b_grant_count: got %0d expected 4", g); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (seq[i] !== exp_g[i]) begin errors++;
        $display("FAIL b2b_grant%0d: got %b expected %b", i, seq[i], exp_g[i]); end
    end
    tick();
    drop_req(0);
    drop_req(1);
    tick();
    tick();
  endtask

  task automatic test_mem_stall();
    mem_data  = 128'h7777;
    stall_cfg = 4;
    drive_req(0, 32'h0000_6000, 1'b0, 1'b0, 16'h0, 128'h0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c <= 5) begin
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h6000) begin errors++;
          $display("FAIL stall_req_c%0d: got %b/%0h expected 1/6000", c, mem_req_valid, mem_addr);
        end
      end
      if (c <= 6) begin
        checks++; if (rw_ready !== 2'b00) begin errors++;
          $display("FAIL stall_early_c%0d: got %b expected 00", c, rw_ready); end
      end else begin
        checks++; if (rw_ready !== 2'b01 || r_data !== 128'h7777) begin errors++;
          $display("FAIL stall_done: got %b/%0h expected 01/7777", rw_ready, r_data); end
      end
    end
    tick();
    drop_req(0);
    stall_cfg = 0;
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    resp_wait = 1000;
    drive_req(0, 32'h0000_7000, 1'b0, 1'b0, 16'h0, 128'h0);
    tick();
    tick();
    tick();
    checks++; if (mem_req_valid !== 1'b0 || mem_addr !== 32'h7000) begin errors++;
      $display("FAIL rstmid_in_wait: got %b/%0h expected 0/7000", mem_req_valid, mem_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'h0 || rw_ready !== 2'b00 || inv_valid !== 2'b00) begin
      errors++; $display("FAIL rstmid_async: got addr=%0h ready=%b inv=%b expected 0/00/00",
                         mem_addr, rw_ready, inv_valid); end
    checks++; if (r_data !== 128'h0) begin errors++;
      $display("FAIL rstmid_rdata: got %0h expected 0", r_data); end
    drop_req(0);
    n = 0;
    tick();
    if (rw_ready !== 2'b00) n++;
    tick();
    rst = 1'b0;
    resp_wait = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rw_ready !== 2'b00) n++;
    end
    checks++; if (n != 0) begin errors++;
      $display("FAIL rstmid_no_ready: got %0d pulses expected 0", n); end
    mem_data = 128'h0BAD_CAFE;
    drive_req(1, 32'h0000_8000, 1'b0, 1'b0, 16'h0, 128'h0);
    wait_ready(1, 10, cyc);
    checks++; if (cyc != 3 || r_data !== 128'h0BAD_CAFE) begin errors++;
      $display("FAIL rstmid_recover: got cyc=%0d data=%0h expected 3/0badcafe", cyc, r_data); end
    tick();
    drop_req(1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rw_valid  = '0;
    rw_addr   = '0;
    rw_we     = '0;
    w_mask    = '0;
    w_data    = '0;
    w_ce      = '0;
    inv_ready = '0;
    mem_data  = '0;
    stall_cfg = 0;
    resp_wait = 0;
    acc_cnt   = 0;
    test_reset();
    test_single_read();
    test_cacheable_write();
    test_write_blocked();
    test_back_to_back();
    test_mem_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
